// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EXE/MEM/WB sequencer for the 16-bit RISC datapath; owns IR and PSW (C/Z/N).
// Latency 3 cycles (CMP/B), 4 (ALU/LLI/LHI/STR), 5 (LDR) at full memory speed.
// Backpressure: MemReady=0 holds IF or MEM one extra cycle each time.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        Reset,
   input  logic [15:0] MemIns,
   input  logic        MemReady,
   input  logic        C,
   input  logic        Z,
   input  logic        N,
   output logic [10:0] Ins,
   output logic        WBRF,
   output logic        WBresource,
   output logic        RBresource,
   output logic        OprandB,
   output logic        LI,
   output logic        Buff_IDEXE,
   output logic        ALUop,
   output logic        Flag,
   output logic        PSW_C,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        PCsrc,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        Illegal,
   output logic        Halted
);

   typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT} state_t;

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_ALUI = 5'b00001;
   localparam logic [4:0] OP_LLI  = 5'b00010;
   localparam logic [4:0] OP_LHI  = 5'b00011;
   localparam logic [4:0] OP_LDR  = 5'b00100;
   localparam logic [4:0] OP_STR  = 5'b00101;
   localparam logic [4:0] OP_CMP  = 5'b00110;
   localparam logic [4:0] OP_B    = 5'b11000;
   localparam logic [4:0] OP_HALT = 5'b11111;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [2:0]  psw_q, psw_d;   // {C, Z, N}

   logic [4:0] op;
   logic is_alu, is_cmp, is_ldr, is_str, is_lhi, is_b, is_halt, legal, br_take;

   logic wbrf_c, wbres_c, rbres_c, oprb_c, li_c, buf_c, aluop_c, flag_c;
   logic irw_c, pcw_c, pcsrc_c, mrd_c, mwr_c, ill_c, halt_c;

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_q <= S_IF;
         ir_q    <= '0;
         psw_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         psw_q   <= psw_d;
      end
   end

   assign op      = ir_q[15:11];
   assign is_alu  = (op == OP_ALU) || (op == OP_ALUI);
   assign is_cmp  = (op == OP_CMP);
   assign is_ldr  = (op == OP_LDR);
   assign is_str  = (op == OP_STR);
   assign is_lhi  = (op == OP_LHI);
   assign is_b    = (op == OP_B);
   assign is_halt = (op == OP_HALT);
   assign legal   = is_alu || is_cmp || is_ldr || is_str || is_lhi || is_b || is_halt
                    || (op == OP_LLI);

   // Branch condition uses the stored PSW, never the live ALU flags.
   always_comb begin
      br_take = 1'b0;
      case (ir_q[10:8])
         3'd0:    br_take = 1'b1;
         3'd1:    br_take = psw_q[1];
         3'd2:    br_take = !psw_q[1];
         3'd3:    br_take = psw_q[2];
         3'd4:    br_take = !psw_q[2];
         3'd5:    br_take = psw_q[0];
         3'd6:    br_take = !psw_q[0];
         default: br_take = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      psw_d   = psw_q;
      wbrf_c  = 1'b0;
      wbres_c = 1'b0;
      rbres_c = 1'b0;
      oprb_c  = 1'b0;
      li_c    = 1'b0;
      buf_c   = 1'b0;
      aluop_c = 1'b0;
      flag_c  = 1'b0;
      irw_c   = 1'b0;
      pcw_c   = 1'b0;
      pcsrc_c = 1'b0;
      mrd_c   = 1'b0;
      mwr_c   = 1'b0;
      ill_c   = 1'b0;
      halt_c  = 1'b0;
      case (state_q)
         S_IF: begin
            mrd_c = 1'b1;
            if (MemReady) begin
               irw_c   = 1'b1;
               pcw_c   = 1'b1;
               ir_d    = MemIns;
               state_d = S_ID;
            end
         end
         S_ID: begin
            buf_c   = 1'b1;
            rbres_c = is_lhi || is_ldr || is_str;
            oprb_c  = (op == OP_ALUI);
            li_c    = is_lhi;
            if (!legal) begin
               ill_c   = 1'b1;
               state_d = S_IF;
            end else if (is_halt) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            if (is_alu) begin
               aluop_c = ir_q[1];
               flag_c  = ir_q[0];
            end else if (is_cmp) begin
               aluop_c = 1'b1;
            end
            if (is_alu || is_cmp) begin
               psw_d = {C, Z, N};
            end
            if (is_b && br_take) begin
               pcw_c   = 1'b1;
               pcsrc_c = 1'b1;
            end
            if (is_ldr || is_str)     state_d = S_MEM;
            else if (is_cmp || is_b)  state_d = S_IF;
            else                      state_d = S_WB;
         end
         S_MEM: begin
            mrd_c = is_ldr;
            mwr_c = is_str;
            if (MemReady) begin
               state_d = is_ldr ? S_WB : S_IF;
            end
         end
         S_WB: begin
            wbrf_c  = 1'b1;
            wbres_c = is_ldr;
            state_d = S_IF;
         end
         S_HALT: begin
            halt_c = 1'b1;
         end
         default: state_d = S_IF;
      endcase
   end

   // Reset low masks every output combinationally, including mid-instruction strobes.
   assign Ins        = Reset ? ir_q[10:0] : 11'd0;
   assign PSW_C      = Reset & psw_q[2];
   assign WBRF       = Reset & wbrf_c;
   assign WBresource = Reset & wbres_c;
   assign RBresource = Reset & rbres_c;
   assign OprandB    = Reset & oprb_c;
   assign LI         = Reset & li_c;
   assign Buff_IDEXE = Reset & buf_c;
   assign ALUop      = Reset & aluop_c;
   assign Flag       = Reset & flag_c;
   assign IRWrite    = Reset & irw_c;
   assign PCWrite    = Reset & pcw_c;
   assign PCsrc      = Reset & pcsrc_c;
   assign MemRead    = Reset & mrd_c;
   assign MemWrite   = Reset & mwr_c;
   assign Illegal    = Reset & ill_c;
   assign Halted     = Reset & halt_c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus latency sequences.
module tb_multicycle_ctrl;

   logic        clk;
   logic        Reset;
   logic [15:0] MemIns;
   logic        MemReady;
   logic        C, Z, N;
   logic [10:0] Ins;
   logic        WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE, ALUop, Flag, PSW_C;
   logic        IRWrite, PCWrite, PCsrc, MemRead, MemWrite, Illegal, Halted;

   multicycle_ctrl dut (
      .clk(clk), .Reset(Reset), .MemIns(MemIns), .MemReady(MemReady),
      .C(C), .Z(Z), .N(N), .Ins(Ins),
      .WBRF(WBRF), .WBresource(WBresource), .RBresource(RBresource), .OprandB(OprandB),
      .LI(LI), .Buff_IDEXE(Buff_IDEXE), .ALUop(ALUop), .Flag(Flag), .PSW_C(PSW_C),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCsrc(PCsrc), .MemRead(MemRead),
      .MemWrite(MemWrite), .Illegal(Illegal), .Halted(Halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [15:0] K_WBRF  = 16'h8000;
   localparam logic [15:0] K_WBRES = 16'h4000;
   localparam logic [15:0] K_RB    = 16'h2000;
   localparam logic [15:0] K_OPB   = 16'h1000;
   localparam logic [15:0] K_LI    = 16'h0800;
   localparam logic [15:0] K_BUF   = 16'h0400;
   localparam logic [15:0] K_ALUOP = 16'h0200;
   localparam logic [15:0] K_FLAG  = 16'h0100;
   localparam logic [15:0] K_PSWC  = 16'h0080;
   localparam logic [15:0] K_IRW   = 16'h0040;
   localparam logic [15:0] K_PCW   = 16'h0020;
   localparam logic [15:0] K_PCSRC = 16'h0010;
   localparam logic [15:0] K_MR    = 16'h0008;
   localparam logic [15:0] K_MW    = 16'h0004;
   localparam logic [15:0] K_ILL   = 16'h0002;
   localparam logic [15:0] K_HALT  = 16'h0001;
   localparam logic [15:0] FETCH   = K_MR | K_IRW | K_PCW;

   typedef struct packed {
      logic        rst_n;
      logic [15:0] mem_ins;
      logic        mem_ready;
      logic [2:0]  czn;
      logic [10:0] exp_ins;
      logic [15:0] exp_ctrl;
   } vec_t;

   vec_t vecs[$];
   int   tests;
   int   fails;

   logic [15:0] ctrl_w;
   assign ctrl_w = {WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE, ALUop, Flag,
                    PSW_C, IRWrite, PCWrite, PCsrc, MemRead, MemWrite, Illegal, Halted};

   function automatic void add(input logic r, input logic [15:0] mi, input logic rdy,
                               input logic [2:0] czn, input logic [10:0] ei,
                               input logic [15:0] ec);
      vec_t v;
      v.rst_n = r; v.mem_ins = mi; v.mem_ready = rdy; v.czn = czn;
      v.exp_ins = ei; v.exp_ctrl = ec;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic measure(input logic [15:0] ins, input int exp_lat, input logic exp_pcsrc,
                          input string name);
      int   lat;
      logic saw;
      @(negedge clk);
      Reset = 1'b0; MemReady = 1'b1; MemIns = ins; {C, Z, N} = 3'b000;
      @(negedge clk);
      Reset = 1'b1;
      lat = -1;
      saw = 1'b0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (k > 0 && IRWrite) begin
            lat = k;
            break;
         end
         saw = saw | PCsrc;
         @(negedge clk);
      end
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_pcsrc"}, {31'd0, saw}, {31'd0, exp_pcsrc});
   endtask

   initial begin
      tests = 0;
      fails = 0;
      Reset = 1'b0; MemIns = 16'h0000; MemReady = 1'b1; {C, Z, N} = 3'b000;

      // reset held three cycles
      add(0, 16'h0001, 1, 3'b000, 11'h000, 16'h0);
      add(0, 16'h0001, 1, 3'b000, 11'h000, 16'h0);
      add(0, 16'h0001, 1, 3'b000, 11'h000, 16'h0);
      // ADC register form, C=1 in EXE
      add(1, 16'h0001, 1, 3'b000, 11'h000, FETCH);
      add(1, 16'h0001, 1, 3'b000, 11'h001, K_BUF);
      add(1, 16'h0001, 1, 3'b100, 11'h001, K_FLAG);
      add(1, 16'h2100, 1, 3'b000, 11'h001, K_WBRF | K_PSWC);
      // LDR, two wait cycles in MEM
      add(1, 16'h2100, 1, 3'b000, 11'h001, FETCH | K_PSWC);
      add(1, 16'h2100, 1, 3'b000, 11'h100, K_BUF | K_RB | K_PSWC);
      add(1, 16'h2100, 0, 3'b000, 11'h100, K_PSWC);
      add(1, 16'h2100, 0, 3'b000, 11'h100, K_MR | K_PSWC);
      add(1, 16'h2100, 0, 3'b000, 11'h100, K_MR | K_PSWC);
      add(1, 16'h2100, 1, 3'b000, 11'h100, K_MR | K_PSWC);
      add(1, 16'h3000, 1, 3'b000, 11'h100, K_WBRF | K_WBRES | K_PSWC);
      // CMP with a one-cycle IF stall, Z=1 in EXE
      add(1, 16'h3000, 0, 3'b000, 11'h100, K_MR | K_PSWC);
      add(1, 16'h3000, 1, 3'b000, 11'h100, FETCH | K_PSWC);
      add(1, 16'hC105, 1, 3'b000, 11'h000, K_BUF | K_PSWC);
      add(1, 16'hC105, 1, 3'b010, 11'h000, K_ALUOP | K_PSWC);
      // B EQ taken, then B NE not taken
      add(1, 16'hC105, 1, 3'b000, 11'h000, FETCH);
      add(1, 16'hC205, 1, 3'b000, 11'h105, K_BUF);
      add(1, 16'hC205, 1, 3'b000, 11'h105, K_PCW | K_PCSRC);
      add(1, 16'hC205, 1, 3'b000, 11'h105, FETCH);
      add(1, 16'h0800, 1, 3'b000, 11'h205, K_BUF);
      add(1, 16'h0800, 1, 3'b000, 11'h205, 16'h0);
      // ALUI ADD sets C=1
      add(1, 16'h0800, 1, 3'b000, 11'h205, FETCH);
      add(1, 16'h2823, 1, 3'b000, 11'h000, K_BUF | K_OPB);
      add(1, 16'h2823, 1, 3'b100, 11'h000, 16'h0);
      add(1, 16'h2823, 1, 3'b000, 11'h000, K_WBRF | K_PSWC);
      // STR aborted by reset in MEM
      add(1, 16'h2823, 1, 3'b000, 11'h000, FETCH | K_PSWC);
      add(1, 16'h2823, 1, 3'b000, 11'h023, K_BUF | K_RB | K_PSWC);
      add(1, 16'h2823, 0, 3'b000, 11'h023, K_PSWC);
      add(1, 16'h2823, 0, 3'b000, 11'h023, K_MW | K_PSWC);
      add(0, 16'h2823, 0, 3'b000, 11'h000, 16'h0);
      add(0, 16'h3800, 1, 3'b000, 11'h000, 16'h0);
      // illegal opcode, then HALT
      add(1, 16'h3800, 1, 3'b000, 11'h000, FETCH);
      add(1, 16'hF800, 1, 3'b000, 11'h000, K_BUF | K_ILL);
      add(1, 16'hF800, 1, 3'b000, 11'h000, FETCH);
      add(1, 16'h0001, 1, 3'b000, 11'h000, K_BUF);
      add(1, 16'h0001, 1, 3'b111, 11'h000, K_HALT);
      add(1, 16'h0001, 1, 3'b111, 11'h000, K_HALT);
      add(1, 16'h0001, 1, 3'b000, 11'h000, K_HALT);
      add(0, 16'h1A34, 1, 3'b000, 11'h000, 16'h0);
      // LHI after leaving HALT
      add(1, 16'h1A34, 1, 3'b000, 11'h000, FETCH);
      add(1, 16'h1A34, 1, 3'b000, 11'h234, K_BUF | K_LI | K_RB);
      add(1, 16'h1A34, 1, 3'b000, 11'h234, 16'h0);
      add(1, 16'h1A34, 1, 3'b000, 11'h234, K_WBRF);
      add(1, 16'h1A34, 1, 3'b000, 11'h234, FETCH);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         Reset    = vecs[i].rst_n;
         MemIns   = vecs[i].mem_ins;
         MemReady = vecs[i].mem_ready;
         {C, Z, N} = vecs[i].czn;
         #1;
         check($sformatf("vec%0d", i), {5'd0, Ins, ctrl_w},
               {5'd0, vecs[i].exp_ins, vecs[i].exp_ctrl});
      end

      measure(16'h2100, 5, 1'b0, "ldr");
      measure(16'h2800, 4, 1'b0, "str");
      measure(16'h0003, 4, 1'b0, "sbc");
      measure(16'h3000, 3, 1'b0, "cmp");
      measure(16'hC000, 3, 1'b1, "b_always");
      measure(16'hC700, 3, 1'b0, "b_never");
      measure(16'hC100, 3, 1'b0, "b_eq_after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
